// File: rtl/tristate_conduit_controller.sv
// ============================================================================
// tristate_conduit_controller: Avalon-MM slave to timed tri-state conduit bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module tristate_conduit_controller #(
   parameter int ADDR_W       = 22,
   parameter int DATA_W       = 8,
   parameter int NUM_CS       = 1,
   parameter int SETUP_CYCLES = 1,
   parameter int READ_WAIT    = 3,
   parameter int WRITE_WAIT   = 2,
   parameter int HOLD_CYCLES  = 1,
   parameter int TA_CYCLES    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [DATA_W-1:0] avs_writedata,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_readdatavalid,
   output logic              avs_waitrequest,
   output logic [ADDR_W-1:0] tcm_address_out,
   output logic              tcm_read_n_out,
   output logic              tcm_write_n_out,
   inout  wire  [DATA_W-1:0] tcm_data_out,
   output logic [NUM_CS-1:0] tcm_chipselect_n_out
);

   localparam int c_CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_SETUP  = 3'd1;
   localparam logic [2:0] c_ACCESS = 3'd2;
   localparam logic [2:0] c_HOLD   = 3'd3;
   localparam logic [2:0] c_TURN   = 3'd4;

   localparam logic [3:0] c_S = 4'(SETUP_CYCLES);
   localparam logic [3:0] c_R = 4'(READ_WAIT);
   localparam logic [3:0] c_W = 4'(WRITE_WAIT);
   localparam logic [3:0] c_H = 4'(HOLD_CYCLES);
   localparam logic [3:0] c_T = 4'(TA_CYCLES);

   localparam logic [NUM_CS-1:0] c_CS_ONE = NUM_CS'(1);

   if (NUM_CS < 1 || NUM_CS > 8 || (NUM_CS & (NUM_CS - 1)) != 0 || ADDR_W < c_CS_W ||
       DATA_W < 1 || SETUP_CYCLES < 0 || SETUP_CYCLES > 15 ||
       READ_WAIT < 1 || READ_WAIT > 15 || WRITE_WAIT < 1 || WRITE_WAIT > 15 ||
       HOLD_CYCLES < 0 || HOLD_CYCLES > 15 || TA_CYCLES < 0 || TA_CYCLES > 15) begin : g_bad_params
      $error("tristate_conduit_controller: parameter out of range");
   end

   logic [c_CS_W-1:0] w_cs_idx;

   if (NUM_CS > 1) begin : g_cs_multi
      assign w_cs_idx = avs_address[ADDR_W-1 -: c_CS_W];
   end else begin : g_cs_single
      assign w_cs_idx = '0;
   end

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_write;
   logic [c_CS_W-1:0] r_cs_idx;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;
   logic              w_accept;
   logic              w_last_read;
   logic              w_active;
   logic              w_drive;

   assign w_accept    = (r_state == c_IDLE) && (avs_read || avs_write);
   assign w_last_read = (r_state == c_ACCESS) && (r_cnt == 4'd1) && !r_write;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= c_IDLE;
         r_cnt    <= 4'd0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_write  <= 1'b0;
         r_cs_idx <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rvalid <= w_last_read;
         if (w_accept) begin
            r_addr   <= avs_address;
            r_wdata  <= avs_writedata;
            r_write  <= avs_write;
            r_cs_idx <= w_cs_idx;
         end
         if (w_last_read) begin
            r_rdata <= tcm_data_out;
         end
      end
   end

   // Zero-length phases are skipped by choosing the first non-empty successor.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_IDLE: begin
            if (avs_read || avs_write) begin
               if (c_S != 4'd0) begin
                  w_state_nxt = c_SETUP;
                  w_cnt_nxt   = c_S;
               end else begin
                  w_state_nxt = c_ACCESS;
                  w_cnt_nxt   = avs_write ? c_W : c_R;
               end
            end
         end
         c_SETUP: begin
            if (r_cnt == 4'd1) begin
               w_state_nxt = c_ACCESS;
               w_cnt_nxt   = r_write ? c_W : c_R;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         c_ACCESS: begin
            if (r_cnt == 4'd1) begin
               if (c_H != 4'd0) begin
                  w_state_nxt = c_HOLD;
                  w_cnt_nxt   = c_H;
               end else if (c_T != 4'd0) begin
                  w_state_nxt = c_TURN;
                  w_cnt_nxt   = c_T;
               end else begin
                  w_state_nxt = c_IDLE;
                  w_cnt_nxt   = 4'd0;
               end
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         c_HOLD: begin
            if (r_cnt == 4'd1) begin
               if (c_T != 4'd0) begin
                  w_state_nxt = c_TURN;
                  w_cnt_nxt   = c_T;
               end else begin
                  w_state_nxt = c_IDLE;
                  w_cnt_nxt   = 4'd0;
               end
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         c_TURN: begin
            if (r_cnt == 4'd1) begin
               w_state_nxt = c_IDLE;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_comb begin
      w_active        = 1'b0;
      tcm_read_n_out  = 1'b1;
      tcm_write_n_out = 1'b1;
      case (r_state)
         c_SETUP, c_HOLD: w_active = 1'b1;
         c_ACCESS: begin
            w_active        = 1'b1;
            tcm_read_n_out  = r_write;
            tcm_write_n_out = !r_write;
         end
         default: w_active = 1'b0;
      endcase
      w_drive              = w_active && r_write;
      tcm_chipselect_n_out = w_active ? ~(c_CS_ONE << r_cs_idx) : '1;
   end

   assign tcm_data_out      = w_drive ? r_wdata : {DATA_W{1'bz}};
   assign tcm_address_out   = r_addr;
   assign avs_readdata      = r_rdata;
   assign avs_readdatavalid = r_rvalid;
   assign avs_waitrequest   = (r_state != c_IDLE) || reset;

endmodule

`default_nettype wire

// File: tb/tb_tristate_conduit_controller.sv
// Testbench for tristate_conduit_controller: default instance driven from a
// per-cycle vector table, plus a 4-chip zero-phase instance driven by hand.
`default_nettype none

module tb_tristate_conduit_controller;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // default-parameter instance
   logic [21:0] a_addr;
   logic        a_rd, a_wr;
   logic [7:0]  a_wd, a_model, a_rdata;
   logic        a_rv, a_wait, a_rn, a_wn;
   logic [21:0] a_taddr;
   logic [0:0]  a_cs;
   wire  [7:0]  a_bus;

   assign a_bus = a_rn ? 8'hzz : a_model;
   pullup (a_bus);

   tristate_conduit_controller dut_a (
      .clk(clk), .reset(reset),
      .avs_address(a_addr), .avs_read(a_rd), .avs_write(a_wr),
      .avs_writedata(a_wd), .avs_readdata(a_rdata),
      .avs_readdatavalid(a_rv), .avs_waitrequest(a_wait),
      .tcm_address_out(a_taddr), .tcm_read_n_out(a_rn),
      .tcm_write_n_out(a_wn), .tcm_data_out(a_bus),
      .tcm_chipselect_n_out(a_cs)
   );

   // four chips, no setup/hold/turnaround, single-cycle read strobe
   logic [21:0] b_addr;
   logic        b_rd, b_wr;
   logic [7:0]  b_wd, b_model, b_rdata;
   logic        b_rv, b_wait, b_rn, b_wn;
   logic [21:0] b_taddr;
   logic [3:0]  b_cs;
   wire  [7:0]  b_bus;

   assign b_bus = b_rn ? 8'hzz : b_model;
   pullup (b_bus);

   tristate_conduit_controller #(
      .NUM_CS(4), .SETUP_CYCLES(0), .READ_WAIT(1), .HOLD_CYCLES(0), .TA_CYCLES(0)
   ) dut_b (
      .clk(clk), .reset(reset),
      .avs_address(b_addr), .avs_read(b_rd), .avs_write(b_wr),
      .avs_writedata(b_wd), .avs_readdata(b_rdata),
      .avs_readdatavalid(b_rv), .avs_waitrequest(b_wait),
      .tcm_address_out(b_taddr), .tcm_read_n_out(b_rn),
      .tcm_write_n_out(b_wn), .tcm_data_out(b_bus),
      .tcm_chipselect_n_out(b_cs)
   );

   typedef struct {
      logic        rst, rd, wr;
      logic [21:0] addr;
      logic [7:0]  wd, model;
      logic        e_wait, e_cs, e_rn, e_wn, e_rv;
      logic [7:0]  e_rd;
      logic [21:0] e_addr;
      logic [7:0]  e_bus;
   } vec_t;

   vec_t vq[$];
   int   n_vec = 0;
   int   n_err = 0;

   logic [21:0] b_addrs [4] = '{22'h000000, 22'h100000, 22'h200000, 22'h3FFFFF};
   logic [7:0]  b_data  [4] = '{8'h81, 8'h42, 8'h24, 8'h18};
   logic [3:0]  b_csexp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   function automatic void add(input logic rst, input logic rd, input logic wr,
                               input logic [21:0] addr, input logic [7:0] wd,
                               input logic [7:0] model, input logic e_wait,
                               input logic e_cs, input logic e_rn, input logic e_wn,
                               input logic e_rv, input logic [7:0] e_rd,
                               input logic [21:0] e_addr, input logic [7:0] e_bus);
      vec_t v;
      v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.model = model;
      v.e_wait = e_wait; v.e_cs = e_cs; v.e_rn = e_rn; v.e_wn = e_wn; v.e_rv = e_rv;
      v.e_rd = e_rd; v.e_addr = e_addr; v.e_bus = e_bus;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      a_addr = '0; a_rd = 1'b0; a_wr = 1'b0; a_wd = '0; a_model = '0;
      b_addr = '0; b_rd = 1'b0; b_wr = 1'b0; b_wd = '0; b_model = '0;

      //   rst rd wr addr       wd     model   wait cs rn wn rv rdata  taddr      bus
      add(1, 0, 0, 22'h0,      8'h00, 8'h00,  1, 1, 1, 1, 0, 8'h00, 22'h0,      8'hFF);
      // write 0xA5 to 0x000123
      add(0, 0, 1, 22'h000123, 8'hA5, 8'h00,  0, 1, 1, 1, 0, 8'h00, 22'h0,      8'hFF);
      add(0, 0, 0, 22'h0,      8'h00, 8'h00,  1, 0, 1, 1, 0, 8'h00, 22'h000123, 8'hA5);
      add(0, 0, 0, 22'h0,      8'h00, 8'h00,  1, 0, 1, 0, 0, 8'h00, 22'h000123, 8'hA5);
      add(0, 0, 0, 22'h0,      8'h00, 8'h00,  1, 0, 1, 0, 0, 8'h00, 22'h000123, 8'hA5);
      add(0, 0, 0, 22'h0,      8'h00, 8'h00,  1, 0, 1, 1, 0, 8'h00, 22'h000123, 8'hA5);
      add(0, 0, 0, 22'h0,      8'h00, 8'h00,  1, 1, 1, 1, 0, 8'h00, 22'h000123, 8'hFF);
      // read 0x3FFFFF, bus returns 0x5A, issued in the first idle cycle
      add(0, 1, 0, 22'h3FFFFF, 8'h00, 8'h5A,  0, 1, 1, 1, 0, 8'h00, 22'h000123, 8'hFF);
      add(0, 0, 0, 22'h0,      8'h00, 8'h5A,  1, 0, 1, 1, 0, 8'h00, 22'h3FFFFF, 8'hFF);
      add(0, 0, 0, 22'h0,      8'h00, 8'h5A,  1, 0, 0, 1, 0, 8'h00, 22'h3FFFFF, 8'h5A);
      add(0, 0, 0, 22'h0,      8'h00, 8'h5A,  1, 0, 0, 1, 0, 8'h00, 22'h3FFFFF, 8'h5A);
      add(0, 0, 0, 22'h0,      8'h00, 8'h5A,  1, 0, 0, 1, 0, 8'h00, 22'h3FFFFF, 8'h5A);
      add(0, 0, 0, 22'h0,      8'h00, 8'h5A,  1, 0, 1, 1, 1, 8'h5A, 22'h3FFFFF, 8'hFF);
      add(0, 0, 0, 22'h0,      8'h00, 8'h5A,  1, 1, 1, 1, 0, 8'h5A, 22'h3FFFFF, 8'hFF);
      // read and write together: write wins
      add(0, 1, 1, 22'h000456, 8'h3C, 8'h77,  0, 1, 1, 1, 0, 8'h5A, 22'h3FFFFF, 8'hFF);
      add(0, 0, 0, 22'h0,      8'h00, 8'h77,  1, 0, 1, 1, 0, 8'h5A, 22'h000456, 8'h3C);
      add(0, 0, 0, 22'h0,      8'h00, 8'h77,  1, 0, 1, 0, 0, 8'h5A, 22'h000456, 8'h3C);
      add(0, 0, 0, 22'h0,      8'h00, 8'h77,  1, 0, 1, 0, 0, 8'h5A, 22'h000456, 8'h3C);
      add(0, 0, 0, 22'h0,      8'h00, 8'h77,  1, 0, 1, 1, 0, 8'h5A, 22'h000456, 8'h3C);
      add(0, 0, 0, 22'h0,      8'h00, 8'h77,  1, 1, 1, 1, 0, 8'h5A, 22'h000456, 8'hFF);
      // read 0x000777, reset lands in cycle 3
      add(0, 1, 0, 22'h000777, 8'h00, 8'h11,  0, 1, 1, 1, 0, 8'h5A, 22'h000456, 8'hFF);
      add(0, 0, 0, 22'h0,      8'h00, 8'h11,  1, 0, 1, 1, 0, 8'h5A, 22'h000777, 8'hFF);
      add(0, 0, 0, 22'h0,      8'h00, 8'h11,  1, 0, 0, 1, 0, 8'h5A, 22'h000777, 8'h11);
      add(1, 0, 0, 22'h0,      8'h00, 8'h11,  1, 0, 0, 1, 0, 8'h5A, 22'h000777, 8'h11);
      for (int k = 0; k < 7; k++)
         add(0, 0, 0, 22'h0,   8'h00, 8'h11,  0, 1, 1, 1, 0, 8'h00, 22'h0,      8'hFF);
      // recovery read 0x000888 returns 0xC3
      add(0, 1, 0, 22'h000888, 8'h00, 8'hC3,  0, 1, 1, 1, 0, 8'h00, 22'h0,      8'hFF);
      add(0, 0, 0, 22'h0,      8'h00, 8'hC3,  1, 0, 1, 1, 0, 8'h00, 22'h000888, 8'hFF);
      add(0, 0, 0, 22'h0,      8'h00, 8'hC3,  1, 0, 0, 1, 0, 8'h00, 22'h000888, 8'hC3);
      add(0, 0, 0, 22'h0,      8'h00, 8'hC3,  1, 0, 0, 1, 0, 8'h00, 22'h000888, 8'hC3);
      add(0, 0, 0, 22'h0,      8'h00, 8'hC3,  1, 0, 0, 1, 0, 8'h00, 22'h000888, 8'hC3);
      add(0, 0, 0, 22'h0,      8'h00, 8'hC3,  1, 0, 1, 1, 1, 8'hC3, 22'h000888, 8'hFF);
      add(0, 0, 0, 22'h0,      8'h00, 8'hC3,  1, 1, 1, 1, 0, 8'hC3, 22'h000888, 8'hFF);
      add(0, 0, 0, 22'h0,      8'h00, 8'hC3,  0, 1, 1, 1, 0, 8'hC3, 22'h000888, 8'hFF);

      repeat (2) @(posedge clk);

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk);
         #1;
         reset = vq[i].rst; a_rd = vq[i].rd; a_wr = vq[i].wr;
         a_addr = vq[i].addr; a_wd = vq[i].wd; a_model = vq[i].model;
         @(negedge clk);
         chk($sformatf("v%0d.waitrequest", i), 32'(a_wait),  32'(vq[i].e_wait));
         chk($sformatf("v%0d.cs_n", i),        32'(a_cs),    32'(vq[i].e_cs));
         chk($sformatf("v%0d.read_n", i),      32'(a_rn),    32'(vq[i].e_rn));
         chk($sformatf("v%0d.write_n", i),     32'(a_wn),    32'(vq[i].e_wn));
         chk($sformatf("v%0d.rdvalid", i),     32'(a_rv),    32'(vq[i].e_rv));
         chk($sformatf("v%0d.readdata", i),    32'(a_rdata), 32'(vq[i].e_rd));
         chk($sformatf("v%0d.address", i),     32'(a_taddr), 32'(vq[i].e_addr));
         chk($sformatf("v%0d.bus", i),         32'(a_bus),   32'(vq[i].e_bus));
      end

      // back-to-back single-cycle reads across the four chips
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         b_rd = 1'b1; b_addr = b_addrs[i];
         @(negedge clk);
         chk($sformatf("b%0d.idle_wait", i), 32'(b_wait), 32'd0);
         chk($sformatf("b%0d.idle_cs_n", i), 32'(b_cs),   32'hF);
         chk($sformatf("b%0d.prev_rv", i),   32'(b_rv),   (i > 0) ? 32'd1 : 32'd0);
         if (i > 0)
            chk($sformatf("b%0d.prev_data", i), 32'(b_rdata), 32'(b_data[i-1]));
         @(posedge clk);
         #1;
         b_rd = 1'b0; b_model = b_data[i];
         @(negedge clk);
         chk($sformatf("b%0d.cs_n", i),    32'(b_cs),    32'(b_csexp[i]));
         chk($sformatf("b%0d.read_n", i),  32'(b_rn),    32'd0);
         chk($sformatf("b%0d.address", i), 32'(b_taddr), 32'(b_addrs[i]));
         chk($sformatf("b%0d.wait", i),    32'(b_wait),  32'd1);
         chk($sformatf("b%0d.rv", i),      32'(b_rv),    32'd0);
      end
      @(posedge clk);
      #1;
      b_wr = 1'b1; b_addr = 22'h2ABCDE; b_wd = 8'h96;
      @(negedge clk);
      chk("b.last_rv",    32'(b_rv),    32'd1);
      chk("b.last_data",  32'(b_rdata), 32'(b_data[3]));
      chk("b.wr_accept",  32'(b_wait),  32'd0);

      // two-cycle write strobe on chip 2, then straight back to idle
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         b_wr = 1'b0; b_wd = 8'h00;
         @(negedge clk);
         chk($sformatf("bw%0d.write_n", c), 32'(b_wn),  32'd0);
         chk($sformatf("bw%0d.read_n", c),  32'(b_rn),  32'd1);
         chk($sformatf("bw%0d.cs_n", c),    32'(b_cs),  32'b1011);
         chk($sformatf("bw%0d.bus", c),     32'(b_bus), 32'h96);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bw.end_wait",    32'(b_wait), 32'd0);
      chk("bw.end_cs_n",    32'(b_cs),   32'hF);
      chk("bw.end_write_n", 32'(b_wn),   32'd1);
      chk("bw.end_bus",     32'(b_bus),  32'hFF);
      chk("bw.end_rv",      32'(b_rv),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
